if_fetch_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage MIPS32 pipeline, directly upstream of the IF/ID pipeline register.
- Owns the PC and drives the instruction-memory request/response handshake.
- Presents {instruction, PC} to IF/ID with IF_over, and flags misaligned PCs via PC_EXC_IF.
- Accepts branch/jump redirects honouring the MIPS delay slot, plus exception redirects that flush the in-flight fetch.

---
 rtl/if_fetch_stage.sv | 142 ++++++++++++++
 tb/tb_if_fetch_stage.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage of the 5-stage MIPS32 pipeline.
// Owns the PC, runs the instruction-memory request/response handshake and
// hands {instruction, PC} to the IF/ID register. Branch/jump redirects honour
// the delay slot; exception redirects flush the in-flight fetch.
// Optional build macro IF_PERF_CNT_EN adds fetch/stall performance counters.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'hBFC0_0000,
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ID_allow_in,
  input  logic        jbr_taken,
  input  logic [31:0] jbr_target,
  input  logic        exc_cancel,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_gnt,
  input  logic        inst_rvalid,
  input  logic [31:0] inst_rdata,
  output logic        IF_over,
  output logic [63:0] IF_OUT,
  output logic        PC_EXC_IF
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  typedef enum logic [2:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_EXC,
    S_DROP
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] jbr_tgt_q;
  logic        jbr_pend;
  logic        pc_misaligned;
  logic        handoff;
  logic        rsp_outstanding;
  logic [31:0] next_pc;

  assign pc_misaligned = |pc[1:0];
  // No request is raised while reset is held, even though the FSM sits in REQ.
  assign inst_req      = reset & (state == S_REQ) & ~pc_misaligned;
  assign inst_addr     = {pc[31:2], 2'b00};
  // An exception flush in the same cycle suppresses the handoff.
  assign handoff       = IF_over & ID_allow_in & ~exc_cancel;
  // A redirect arriving together with the handoff is applied immediately.
  assign next_pc       = jbr_taken ? jbr_target :
                         (jbr_pend ? jbr_tgt_q : pc + 32'd4);
  // A memory response is still owed when a request was accepted and its data
  // has not yet been seen; a response landing this very cycle settles it.
  assign rsp_outstanding = (((state == S_WAIT) || (state == S_DROP)) & ~inst_rvalid)
                         | (inst_req & inst_gnt);

  // Redirect target register (pure data, no reset needed).
  always_ff @(posedge clk) begin
    if (jbr_taken && !exc_cancel) begin
      jbr_tgt_q <= jbr_target;
    end
  end

  // Fetch FSM: PC, pending redirect and the registered IF/ID-facing outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_REQ;
      pc        <= RESET_PC;
      jbr_pend  <= 1'b0;
      IF_over   <= 1'b0;
      IF_OUT    <= '0;
      PC_EXC_IF <= 1'b0;
    end else if (exc_cancel) begin
      pc        <= EXC_VECTOR;
      jbr_pend  <= 1'b0;
      IF_over   <= 1'b0;
      PC_EXC_IF <= 1'b0;
      state     <= rsp_outstanding ? S_DROP : S_REQ;
    end else begin
      if (jbr_taken) begin
        jbr_pend <= 1'b1;
      end
      case (state)
        S_REQ: begin
          if (pc_misaligned) begin
            state     <= S_EXC;
            IF_over   <= 1'b1;
            PC_EXC_IF <= 1'b1;
            IF_OUT    <= {32'b0, pc};
          end else if (inst_gnt) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (inst_rvalid) begin
            IF_OUT  <= {inst_rdata, pc};
            IF_over <= 1'b1;
            state   <= S_HOLD;
          end
        end
        S_HOLD, S_EXC: begin
          if (handoff) begin
            pc        <= next_pc;
            jbr_pend  <= 1'b0;
            IF_over   <= 1'b0;
            PC_EXC_IF <= 1'b0;
            state     <= S_REQ;
          end
        end
        S_DROP: begin
          if (inst_rvalid) begin
            state <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

`ifdef IF_PERF_CNT_EN
  // Performance counters: completed handoffs and cycles stalled by ID.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (handoff) begin
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      end
      if (IF_over && !ID_allow_in) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: behavioural instruction memory,
// request-address and handoff scoreboards, directed redirect/exception cases.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ID_allow_in = 1'b1;
  logic        jbr_taken = 1'b0;
  logic [31:0] jbr_target = '0;
  logic        exc_cancel = 1'b0;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_gnt;
  logic        inst_rvalid = 1'b0;
  logic [31:0] inst_rdata = '0;
  logic        IF_over;
  logic [63:0] IF_OUT;
  logic        PC_EXC_IF;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
  logic [31:0] stall_base;
`endif

  if_fetch_stage dut (
    .clk         (clk),
    .reset       (reset),
    .ID_allow_in (ID_allow_in),
    .jbr_taken   (jbr_taken),
    .jbr_target  (jbr_target),
    .exc_cancel  (exc_cancel),
    .inst_req    (inst_req),
    .inst_addr   (inst_addr),
    .inst_gnt    (inst_gnt),
    .inst_rvalid (inst_rvalid),
    .inst_rdata  (inst_rdata),
    .IF_over     (IF_over),
    .IF_OUT      (IF_OUT),
    .PC_EXC_IF   (PC_EXC_IF)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Memory always grants in the request cycle.
  assign inst_gnt = inst_req;

  int n_checks = 0;
  int n_errors = 0;
  int n_handoff = 0;

  logic [31:0] exp_addr_q[$];
  logic [64:0] exp_out_q[$];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'hBFC0_0000) ? 32'h2408_0001 : ~a;
  endfunction

  function automatic void push_out(input logic [31:0] ir, input logic [31:0] pc, input logic exc);
    exp_out_q.push_back({exc, ir, pc});
  endfunction

  // Behavioural memory: response lat cycles after the grant.
  int          lat = 1;
  int          cyc = 0;
  logic [31:0] rq_addr[$];
  int          rq_due[$];
  always begin
    @(negedge clk);
    if (inst_req && inst_gnt) begin
      rq_addr.push_back(inst_addr);
      rq_due.push_back(cyc + lat);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rq_due.size() > 0 && rq_due[0] == cyc) begin
      inst_rvalid = 1'b1;
      inst_rdata  = mem_word(rq_addr[0]);
      void'(rq_addr.pop_front());
      void'(rq_due.pop_front());
    end else begin
      inst_rvalid = 1'b0;
      inst_rdata  = '0;
    end
  end

  // Scoreboard monitor: request addresses, handoff contents, output stability.
  logic        hand;
  logic        prev_over = 1'b0;
  logic        prev_hand = 1'b0;
  logic [63:0] prev_out = '0;
  logic [31:0] ea;
  logic [64:0] eo;
  always @(negedge clk) begin
    hand = IF_over && ID_allow_in && !exc_cancel;
    if (reset && inst_req && inst_gnt) begin
      check_val("req_expected", 64'(exp_addr_q.size() > 0), 64'd1);
      if (exp_addr_q.size() > 0) begin
        ea = exp_addr_q.pop_front();
        check_val("req_addr", 64'(inst_addr), 64'(ea));
      end
    end
    if (reset && hand) begin
      n_handoff++;
      check_val("handoff_expected", 64'(exp_out_q.size() > 0), 64'd1);
      if (exp_out_q.size() > 0) begin
        eo = exp_out_q.pop_front();
        check_val("handoff_if_out", IF_OUT, eo[63:0]);
        check_val("handoff_pc_exc", 64'(PC_EXC_IF), 64'(eo[64]));
      end
    end
    if (IF_over && prev_over && !prev_hand) begin
      check_val("if_out_stable", IF_OUT, prev_out);
    end
    prev_over = IF_over;
    prev_hand = hand;
    prev_out  = IF_OUT;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input logic [31:0] a);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (inst_req && inst_gnt && inst_addr == a) seen = 1'b1;
    end
    check_val($sformatf("grant_%h", a), 64'(seen), 64'd1);
  endtask

  task automatic wait_over();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (IF_over) seen = 1'b1;
    end
    check_val("wait_if_over", 64'(seen), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst_inst_req", 64'(inst_req), 64'd0);
    check_val("rst_if_over", 64'(IF_over), 64'd0);
    check_val("rst_if_out", IF_OUT, 64'd0);
    check_val("rst_pc_exc", 64'(PC_EXC_IF), 64'd0);
`ifdef IF_PERF_CNT_EN
    check_val("rst_perf_fetch", 64'(perf_fetch_cnt), 64'd0);
    check_val("rst_perf_stall", 64'(perf_stall_cnt), 64'd0);
`endif

    // First fetch from the reset vector, then a 5-cycle ID stall.
    exp_addr_q.push_back(32'hBFC0_0000);
    push_out(32'h2408_0001, 32'hBFC0_0000, 1'b0);
    exp_addr_q.push_back(32'hBFC0_0004);
    push_out(~32'hBFC0_0004, 32'hBFC0_0004, 1'b0);
    step();
    reset = 1'b1;
    wait_grant(32'hBFC0_0000);
    step();
    step();
    @(negedge clk);
    check_val("first_if_out", IF_OUT, {32'h2408_0001, 32'hBFC0_0000});
    wait_grant(32'hBFC0_0004);
    step();
    ID_allow_in = 1'b0;
    step();
`ifdef IF_PERF_CNT_EN
    stall_base = perf_stall_cnt;
`endif
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("stall_if_over", 64'(IF_over), 64'd1);
      check_val("stall_no_req", 64'(inst_req), 64'd0);
      check_val("stall_if_out", IF_OUT, {~32'hBFC0_0004, 32'hBFC0_0004});
      step();
    end
`ifdef IF_PERF_CNT_EN
    check_val("perf_stall_5", 64'(perf_stall_cnt - stall_base), 64'd5);
`endif
    ID_allow_in = 1'b1;

    // Branch during WAIT: BFC00008 is the delay slot, then 80000100.
    exp_addr_q.push_back(32'hBFC0_0008);
    push_out(~32'hBFC0_0008, 32'hBFC0_0008, 1'b0);
    exp_addr_q.push_back(32'h8000_0100);
    push_out(~32'h8000_0100, 32'h8000_0100, 1'b0);
    exp_addr_q.push_back(32'hBFC0_0010);
    wait_grant(32'hBFC0_0008);
    step();
    jbr_taken  = 1'b1;
    jbr_target = 32'h8000_0100;
    step();
    jbr_taken = 1'b0;

    // Redirect coinciding with handoff of 80000100 goes straight to BFC00010.
    wait_grant(32'h8000_0100);
    step();
    step();
    jbr_taken  = 1'b1;
    jbr_target = 32'hBFC0_0010;
    lat        = 2;
    step();
    jbr_taken = 1'b0;

    // Exception while BFC00010 waits: its response is dropped.
    wait_grant(32'hBFC0_0010);
    step();
    exc_cancel = 1'b1;
    @(negedge clk);
    check_val("exc_wait_if_over", 64'(IF_over), 64'd0);
    step();
    exc_cancel = 1'b0;
    @(negedge clk);
    check_val("drop_if_over", 64'(IF_over), 64'd0);
    lat = 1;
    exp_addr_q.push_back(32'hBFC0_0380);
    push_out(~32'hBFC0_0380, 32'hBFC0_0380, 1'b0);

    // Branch to a misaligned target: PC exception without a memory request.
    wait_grant(32'hBFC0_0380);
    step();
    jbr_taken  = 1'b1;
    jbr_target = 32'h8000_0102;
    step();
    jbr_taken = 1'b0;
    step();
    ID_allow_in = 1'b0;
    wait_over();
    check_val("misalign_pc_exc", 64'(PC_EXC_IF), 64'd1);
    check_val("misalign_if_out", IF_OUT, {32'h0, 32'h8000_0102});
    check_val("misalign_no_req", 64'(inst_req), 64'd0);

    // Same-cycle jump and exception: exception wins, pending jump dropped.
    exp_addr_q.push_back(32'hBFC0_0380);
    push_out(~32'hBFC0_0380, 32'hBFC0_0380, 1'b0);
    exp_addr_q.push_back(32'hBFC0_0384);
    step();
    ID_allow_in = 1'b1;
    jbr_taken   = 1'b1;
    jbr_target  = 32'h8000_0200;
    exc_cancel  = 1'b1;
    step();
    jbr_taken  = 1'b0;
    exc_cancel = 1'b0;
    @(negedge clk);
    check_val("exc_if_over_clr", 64'(IF_over), 64'd0);
    check_val("exc_pc_exc_clr", 64'(PC_EXC_IF), 64'd0);
    wait_grant(32'hBFC0_0384);
    step();
    ID_allow_in = 1'b0;
    step();
    step();
    @(negedge clk);
    check_val("final_if_over", 64'(IF_over), 64'd1);
    check_val("final_if_out", IF_OUT, {~32'hBFC0_0384, 32'hBFC0_0384});
`ifdef IF_PERF_CNT_EN
    check_val("perf_fetch", 64'(perf_fetch_cnt), 64'(n_handoff));
`endif
    check_val("addr_q_drained", 64'(exp_addr_q.size()), 64'd0);
    check_val("out_q_drained", 64'(exp_out_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
